to_lower_stream: RTL
====================

TO_LOWER_STREAM -- requirements
Module: to_lower_stream

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of conv_count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream byte present.
REQ-006 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port in_data  input  8  ASCII byte from upstream.
REQ-008 SHALL have port out_valid  output  1  converted byte present.
REQ-009 SHALL have port out_ready  input  1  downstream accepts byte this cycle.
REQ-010 SHALL have port out_data  output  8  converted byte, FIFO head.
REQ-011 SHALL have port conv_count  output  CNT_W  number of bytes case-converted since reset.
REQ-012 SHALL have port clr_count  input  1  synchronous clear of conv_count.

Function
REQ-013 SHALL treat the input as accepted (push) on a rising edge where in_valid && in_ready.
REQ-014 SHALL treat the head as consumed (pop) on a rising edge where out_valid && out_ready.
REQ-015 SHALL convert on push: in_data in 0x41..0x5A ('A'..'Z') stored as in_data | 0x20; every other value stored unchanged.
REQ-016 SHALL leave 0x40, 0x5B, 0x60..0x7F, and all bytes >= 0x80 (incl. 0xC0..0xDE) unmodified.
REQ-017 SHALL store bytes in a DEPTH-entry circular FIFO with read/write pointers wrapping from DEPTH-1 to 0.
REQ-018 SHALL drive in_ready = 1 iff occupancy < DEPTH; in_ready SHALL NOT depend combinationally on out_ready (no pass-through when full).
REQ-019 SHALL drive out_valid = 1 iff occupancy > 0, out_data = entry at read pointer.
REQ-020 SHALL have latency 1: byte pushed at edge N into an empty FIFO is presented with out_valid = 1 in the cycle after edge N.
REQ-021 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, on simultaneous push and pop, keep occupancy unchanged and advance both pointers; with occupancy 1 the new byte becomes head next cycle.
REQ-023 SHALL ignore in_data when in_valid = 0 or in_ready = 0 (no state change).
REQ-024 SHALL preserve byte order exactly; no drops, no duplicates.
REQ-025 SHALL increment conv_count by 1 on each push whose byte was in 0x41..0x5A, saturating at 2^CNT_W-1.
REQ-026 SHALL clear conv_count to 0 on an edge with clr_count = 1; clr_count SHALL take priority over a simultaneous increment.
REQ-027 SHALL track occupancy in a counter of width log2(DEPTH)+1, range 0..DEPTH.

Reset
REQ-028 SHALL, on an edge with rst = 1, set occupancy 0, both pointers 0, conv_count 0; outputs next cycle: out_valid 0, in_ready 1.
REQ-029 SHALL give rst priority over push, pop and clr_count on the same edge; FIFO contents in flight are discarded.
REQ-030 SHALL leave FIFO storage contents undefined after reset; out_data is don't-care while out_valid = 0.

Verification
REQ-031 Single byte: push 0x41 with out_ready=1 -> next cycle out_valid=1, out_data=0x61; conv_count=1.
REQ-032 Boundaries: push 0x40,0x41,0x5A,0x5B,0x61,0xC1 -> outputs 0x40,0x61,0x7A,0x5B,0x61,0xC1; conv_count=2.
REQ-033 Backpressure/full: out_ready=0, push 5 bytes with DEPTH=4 -> 4 accepted, in_ready=0 after fourth, out_data held; release out_ready -> 4 bytes in order, then in_ready=1.
REQ-034 Simultaneous: occupancy 2, push and pop same edge for 10 cycles -> occupancy stays 2, pointer wrap seen, order intact.
REQ-035 Reset mid-stream: occupancy 3, assert rst one edge with in_valid=1 -> next cycle out_valid=0, in_ready=1, conv_count=0, pushed byte lost.
REQ-036 Counter: CNT_W=4, push 17 uppercase bytes -> conv_count saturates at 15; clr_count with uppercase push same edge -> conv_count=0.

Source files
------------

// File: rtl/to_lower_stream_if.sv
// Byte-stream handshake bundle for the to_lower_stream block: upstream push side and downstream pop side.
// The master modport is the environment (source and sink), the slave modport is the converter.
interface to_lower_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/to_lower_stream.sv
// Streaming ASCII upper-to-lower case converter with a DEPTH-entry circular FIFO
// and a saturating count of converted bytes.
module to_lower_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    to_lower_stream_if.slave bus,
    output logic [CNT_W-1:0] conv_count,
    input  logic             clr_count
);
    localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      FULL    = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          is_upper;
    logic [7:0]    stored;

    // in_ready looks only at occupancy, so a full FIFO never passes a byte through on a pop
    assign bus.in_ready  = (count < FULL);
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];

    assign push     = bus.in_valid && bus.in_ready;
    assign pop      = bus.out_valid && bus.out_ready;
    assign is_upper = (bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A);
    assign stored   = is_upper ? (bus.in_data | 8'h20) : bus.in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            conv_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (clr_count) begin
                conv_count <= '0;
            end else if (push && is_upper && (conv_count != CNT_MAX)) begin
                conv_count <= conv_count + 1'b1;
            end
        end
    end

    // Storage has no reset; entries are only meaningful while counted in occupancy
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= stored;
        end
    end
endmodule
